prbs_sync_ctrl: RTL and testbench

Sequencing controller for the 25-bit PRBS (x^25+x^22+1) TX/RX datapath. It drives the RX instance's bus-load mode to seed the receiver LFSR from the incoming bit stream, then switches it to free-running mode and verifies alignment using the datapath match flag (CMP, high = match). Once locked, it measures errors over fixed bit windows, declares loss of lock, resynchronises automatically, and keeps error and resync statistics.

---
 rtl/prbs_sync_ctrl.sv | 165 ++++++++++++++++
 tb/tb_prbs_sync_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_sync_ctrl.sv
// Sync sequencer for a 25-bit PRBS RX path: seed LFSR (LOAD), verify alignment, hold lock and track errors.
// Latency: all outputs registered, one CK_i after the deciding enabled edge; phase lengths counted in CK_EE_i bits.
// Backpressure: none; CK_EE_i paces the bit stream, START_i/CLR_i act on every CK_i edge.
//
// Ports:
//   CK_i, RST_i (sync, active high), CK_EE_i (bit enable), START_i (run level), CLR_i (stats clear)
//   CMP_i (datapath match flag), BUS_RX_MODE_o (1 = RX LFSR loads from RXD), LOCK_o, STATE_o
//   ERR_CNT_o (saturating locked errors), WIN_ERR_o / WIN_DONE_o (per-window result), RESYNC_CNT_o
module prbs_sync_ctrl #(
    parameter int C_LOAD_LEN = 25,
    parameter int C_CMP_LAT  = 1,
    parameter int C_CHK_LEN  = 64,
    parameter int C_WIN_LEN  = 1024,
    parameter int C_LOSS_THR = 8,
    parameter int C_CNT_W    = 16
) (
    input  logic                          CK_i,
    input  logic                          RST_i,
    input  logic                          CK_EE_i,
    input  logic                          START_i,
    input  logic                          CLR_i,
    input  logic                          CMP_i,
    output logic                          BUS_RX_MODE_o,
    output logic                          LOCK_o,
    output logic [1:0]                    STATE_o,
    output logic [C_CNT_W-1:0]            ERR_CNT_o,
    output logic [$clog2(C_WIN_LEN):0]    WIN_ERR_o,
    output logic                          WIN_DONE_o,
    output logic [7:0]                    RESYNC_CNT_o
);

    localparam int WIN_W = $clog2(C_WIN_LEN) + 1;
    localparam int W_A   = $clog2(C_LOAD_LEN + 1);
    localparam int W_B   = $clog2(C_CMP_LAT + 1);
    localparam int W_C   = $clog2(C_WIN_LEN + 1);
    localparam int W_AB  = (W_A > W_B) ? W_A : W_B;
    // One bit counter is shared by LOAD length, VERIFY latency skip and LOCKED window position.
    localparam int CNT_W = (W_AB > W_C) ? W_AB : W_C;
    localparam int RUN_W = $clog2(C_CHK_LEN + 1);

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(C_LOAD_LEN - 1);
    localparam logic [CNT_W-1:0] LAT_V     = CNT_W'(C_CMP_LAT);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(C_WIN_LEN - 1);
    localparam logic [RUN_W-1:0] CHK_LAST  = RUN_W'(C_CHK_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [RUN_W-1:0]   run_cnt;
    logic [WIN_W-1:0]   win_err;
    logic [WIN_W-1:0]   win_err_nxt;
    logic               win_lost;

    // Window error count including the bit currently being judged.
    assign win_err_nxt = win_err + WIN_W'(~CMP_i);
    // Full-width unsigned compare so a threshold beyond the counter range can never trigger.
    assign win_lost    = 32'(win_err_nxt) >= 32'(C_LOSS_THR);
    assign STATE_o     = state;

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            run_cnt       <= '0;
            win_err       <= '0;
            BUS_RX_MODE_o <= 1'b0;
            LOCK_o        <= 1'b0;
            ERR_CNT_o     <= '0;
            WIN_ERR_o     <= '0;
            WIN_DONE_o    <= 1'b0;
            RESYNC_CNT_o  <= '0;
        end else begin
            WIN_DONE_o <= 1'b0;

            if (CK_EE_i) begin
                case (state)
                    ST_IDLE: begin
                        if (START_i) begin
                            state         <= ST_LOAD;
                            BUS_RX_MODE_o <= 1'b1;
                            bit_cnt       <= '0;
                        end
                    end

                    ST_LOAD: begin
                        if (bit_cnt == LOAD_LAST) begin
                            state         <= ST_VERIFY;
                            BUS_RX_MODE_o <= 1'b0;
                            bit_cnt       <= '0;
                            run_cnt       <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end

                    ST_VERIFY: begin
                        if (bit_cnt < LAT_V) begin
                            // Compare pipeline still holds pre-switch bits; skip them.
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end else if (!CMP_i) begin
                            state         <= ST_LOAD;
                            BUS_RX_MODE_o <= 1'b1;
                            bit_cnt       <= '0;
                            run_cnt       <= '0;
                            // An abort on this same edge is not a resync.
                            if (START_i && RESYNC_CNT_o != 8'hFF)
                                RESYNC_CNT_o <= RESYNC_CNT_o + 8'd1;
                        end else if (run_cnt == CHK_LAST) begin
                            state   <= ST_LOCKED;
                            LOCK_o  <= 1'b1;
                            bit_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            run_cnt <= run_cnt + RUN_W'(1);
                        end
                    end

                    ST_LOCKED: begin
                        if (!CMP_i && ERR_CNT_o != {C_CNT_W{1'b1}})
                            ERR_CNT_o <= ERR_CNT_o + C_CNT_W'(1);
                        if (bit_cnt == WIN_LAST) begin
                            WIN_ERR_o  <= win_err_nxt;
                            WIN_DONE_o <= 1'b1;
                            bit_cnt    <= '0;
                            win_err    <= '0;
                            if (win_lost) begin
                                state         <= ST_LOAD;
                                LOCK_o        <= 1'b0;
                                BUS_RX_MODE_o <= 1'b1;
                                if (START_i && RESYNC_CNT_o != 8'hFF)
                                    RESYNC_CNT_o <= RESYNC_CNT_o + 8'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            win_err <= win_err_nxt;
                        end
                    end
                endcase
            end

            // Abort overrides the state transition but leaves window results of this edge intact.
            if (!START_i) begin
                state         <= ST_IDLE;
                BUS_RX_MODE_o <= 1'b0;
                LOCK_o        <= 1'b0;
                bit_cnt       <= '0;
                run_cnt       <= '0;
                win_err       <= '0;
            end

            // Clear beats any increment made above on the same edge.
            if (CLR_i) begin
                ERR_CNT_o    <= '0;
                RESYNC_CNT_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs_sync_ctrl.sv
// Self-checking bench for prbs_sync_ctrl: directed acquisition/window scenarios plus randomized soak.
// Latency: outputs compared every CK_i against a bit-level reference model, sampled on the falling edge.
// Backpressure: none; stimulus drives CK_EE_i/START_i/CLR_i/CMP_i directly.
module tb_prbs_sync_ctrl;

    localparam int C_LOAD_LEN = 25;
    localparam int C_CMP_LAT  = 1;
    localparam int C_CHK_LEN  = 64;
    localparam int C_WIN_LEN  = 1024;
    localparam int C_LOSS_THR = 8;
    localparam int C_CNT_W    = 16;
    localparam int WIN_W      = $clog2(C_WIN_LEN) + 1;
    localparam int ERR_MAX    = (1 << C_CNT_W) - 1;

    logic                CK_i = 1'b0;
    logic                RST_i, CK_EE_i, START_i, CLR_i, CMP_i;
    logic                BUS_RX_MODE_o, LOCK_o, WIN_DONE_o;
    logic [1:0]          STATE_o;
    logic [C_CNT_W-1:0]  ERR_CNT_o;
    logic [WIN_W-1:0]    WIN_ERR_o;
    logic [7:0]          RESYNC_CNT_o;

    prbs_sync_ctrl #(
        .C_LOAD_LEN (C_LOAD_LEN),
        .C_CMP_LAT  (C_CMP_LAT),
        .C_CHK_LEN  (C_CHK_LEN),
        .C_WIN_LEN  (C_WIN_LEN),
        .C_LOSS_THR (C_LOSS_THR),
        .C_CNT_W    (C_CNT_W)
    ) dut (
        .CK_i          (CK_i),
        .RST_i         (RST_i),
        .CK_EE_i       (CK_EE_i),
        .START_i       (START_i),
        .CLR_i         (CLR_i),
        .CMP_i         (CMP_i),
        .BUS_RX_MODE_o (BUS_RX_MODE_o),
        .LOCK_o        (LOCK_o),
        .STATE_o       (STATE_o),
        .ERR_CNT_o     (ERR_CNT_o),
        .WIN_ERR_o     (WIN_ERR_o),
        .WIN_DONE_o    (WIN_DONE_o),
        .RESYNC_CNT_o  (RESYNC_CNT_o)
    );

    always #5 CK_i = ~CK_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase numbers follow the published STATE_o values; counts are bits consumed.
    int m_phase, m_bits, m_run, m_werr;
    int m_err, m_resync, m_win_out, m_done;

    task automatic model_step();
        int lost;
        if (RST_i) begin
            m_phase = 0; m_bits = 0; m_run = 0; m_werr = 0;
            m_err = 0; m_resync = 0; m_win_out = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (CK_EE_i) begin
            if (m_phase == 0) begin
                if (START_i) begin m_phase = 1; m_bits = 0; end
            end else if (m_phase == 1) begin
                m_bits++;
                if (m_bits == C_LOAD_LEN) begin m_phase = 2; m_bits = 0; m_run = 0; end
            end else if (m_phase == 2) begin
                m_bits++;
                if (m_bits > C_CMP_LAT) begin
                    if (!CMP_i) begin
                        m_phase = 1; m_bits = 0;
                        if (START_i) m_resync = (m_resync < 255) ? m_resync + 1 : 255;
                    end else begin
                        m_run++;
                        if (m_run == C_CHK_LEN) begin m_phase = 3; m_bits = 0; m_werr = 0; end
                    end
                end
            end else begin
                m_bits++;
                if (!CMP_i) begin
                    m_werr++;
                    m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
                end
                if (m_bits == C_WIN_LEN) begin
                    m_win_out = m_werr;
                    m_done = 1;
                    lost = (m_werr >= C_LOSS_THR);
                    m_bits = 0; m_werr = 0;
                    if (lost) begin
                        m_phase = 1;
                        if (START_i) m_resync = (m_resync < 255) ? m_resync + 1 : 255;
                    end
                end
            end
        end
        if (!START_i) begin m_phase = 0; m_bits = 0; m_run = 0; m_werr = 0; end
        if (CLR_i) begin m_err = 0; m_resync = 0; end
    endtask

    task automatic check_outputs();
        check_val("state",  32'(STATE_o),       32'(m_phase));
        check_val("bus_rx", 32'(BUS_RX_MODE_o), 32'(m_phase == 1));
        check_val("lock",   32'(LOCK_o),        32'(m_phase == 3));
        check_val("err",    32'(ERR_CNT_o),     32'(m_err));
        check_val("winerr", 32'(WIN_ERR_o),     32'(m_win_out));
        check_val("wdone",  32'(WIN_DONE_o),    32'(m_done));
        check_val("resync", 32'(RESYNC_CNT_o),  32'(m_resync));
    endtask

    task automatic cycle(input logic rst, input logic ee, input logic start,
                         input logic clr, input logic cmp);
        RST_i = rst; CK_EE_i = ee; START_i = start; CLR_i = clr; CMP_i = cmp;
        @(posedge CK_i);
        model_step();
        @(negedge CK_i);
        check_outputs();
    endtask

    logic errpos [C_WIN_LEN];

    task automatic run_window(input int nerr);
        int placed;
        int p;
        placed = 0;
        for (int i = 0; i < C_WIN_LEN; i++) errpos[i] = 1'b0;
        while (placed < nerr) begin
            p = $urandom_range(C_WIN_LEN - 1);
            if (!errpos[p]) begin errpos[p] = 1'b1; placed++; end
        end
        for (int i = 0; i < C_WIN_LEN; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, ~errpos[i]);
    endtask

    task automatic run_to_lock(input int budget);
        int b;
        b = 0;
        while (!LOCK_o && b < budget) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            b++;
        end
    endtask

    initial begin
        int n_load, n_ver, b, fail_cyc;
        int ee_pct, err_mode;
        logic cmp;

        RST_i = 1'b1; CK_EE_i = 1'b1; START_i = 1'b1; CLR_i = 1'b0; CMP_i = 1'b1;
        m_phase = 0; m_bits = 0; m_run = 0; m_werr = 0;
        m_err = 0; m_resync = 0; m_win_out = 0; m_done = 0;

        // Reset held with START high.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check_val("rst_state", 32'(STATE_o), 32'd0);
        check_val("rst_lock",  32'(LOCK_o),  32'd0);
        check_val("rst_bus",   32'(BUS_RX_MODE_o), 32'd0);

        // Clean acquisition straight out of reset.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check_val("rel_state", 32'(STATE_o), 32'd1);
        n_load = 1; n_ver = 0; b = 0;
        while (!LOCK_o && b < 500) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            if (STATE_o == 2'd1) n_load++;
            if (STATE_o == 2'd2) n_ver++;
            b++;
        end
        check_val("acq_load_len", 32'(n_load), 32'(C_LOAD_LEN));
        check_val("acq_ver_len",  32'(n_ver),  32'(C_CMP_LAT + C_CHK_LEN));
        check_val("acq_lock",     32'(LOCK_o), 32'd1);
        check_val("acq_resync",   32'(RESYNC_CNT_o), 32'd0);

        // Window with errors below threshold, then one at threshold.
        run_window(7);
        check_val("w7_done", 32'(WIN_DONE_o), 32'd1);
        check_val("w7_err",  32'(WIN_ERR_o),  32'd7);
        check_val("w7_cnt",  32'(ERR_CNT_o),  32'd7);
        check_val("w7_lock", 32'(LOCK_o),     32'd1);
        run_window(8);
        check_val("w8_err",    32'(WIN_ERR_o),    32'd8);
        check_val("w8_state",  32'(STATE_o),      32'd1);
        check_val("w8_lock",   32'(LOCK_o),       32'd0);
        check_val("w8_resync", 32'(RESYNC_CNT_o), 32'd1);
        check_val("w8_cnt",    32'(ERR_CNT_o),    32'd15);
        run_to_lock(200);
        check_val("relock", 32'(LOCK_o), 32'd1);

        // CLR together with an error bit.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("clr_err",    32'(ERR_CNT_o),    32'd0);
        check_val("clr_resync", 32'(RESYNC_CNT_o), 32'd0);

        // VERIFY failure on the 10th checked bit.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        fail_cyc = 1 + C_LOAD_LEN + C_CMP_LAT + 10;
        for (int i = 1; i <= fail_cyc; i++)
            cycle(1'b0, 1'b1, 1'b1, 1'b0, (i == fail_cyc) ? 1'b0 : 1'b1);
        check_val("vf_state",  32'(STATE_o),      32'd1);
        check_val("vf_resync", 32'(RESYNC_CNT_o), 32'd1);
        run_to_lock(200);
        check_val("vf_relock", 32'(LOCK_o),       32'd1);
        check_val("vf_resync2", 32'(RESYNC_CNT_o), 32'd1);

        // Abort in the middle of LOAD on a disabled cycle.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("abort_state", 32'(STATE_o),       32'd0);
        check_val("abort_bus",   32'(BUS_RX_MODE_o), 32'd0);

        // Enable 1 of every 4 cycles: phases stretch by 4.
        n_load = 0; n_ver = 0; b = 0;
        while (!LOCK_o && b < 2000) begin
            cycle(1'b0, (b % 4) == 0, 1'b1, 1'b0, 1'b1);
            if (STATE_o == 2'd1) n_load++;
            if (STATE_o == 2'd2) n_ver++;
            b++;
        end
        check_val("ee4_load_len", 32'(n_load), 32'(4 * C_LOAD_LEN));
        check_val("ee4_ver_len",  32'(n_ver),  32'(4 * (C_CMP_LAT + C_CHK_LEN)));
        check_val("ee4_lock",     32'(LOCK_o), 32'd1);

        // Randomized soak against the model.
        for (int seg = 0; seg < 8; seg++) begin
            ee_pct   = (seg % 3 == 0) ? 100 : ((seg % 3 == 1) ? 50 : 25);
            err_mode = $urandom_range(2);
            for (int i = 0; i < 1500; i++) begin
                if (err_mode == 0)      cmp = 1'b1;
                else if (err_mode == 1) cmp = ($urandom_range(1999) != 0);
                else                    cmp = ($urandom_range(63) != 0);
                cycle($urandom_range(4999) == 0,
                      $urandom_range(99) < ee_pct,
                      $urandom_range(2999) != 0,
                      $urandom_range(1999) == 0,
                      cmp);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
